// File: rtl/key_schedule_engine.sv
// AES key expansion engine: expands a 128/192/256-bit cipher key into the full
// round-key schedule one word per cycle, then serves round keys on request.

module key_schedule_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Forward AES S-box, entry n occupies bits 8n..8n+7 (MSB first).
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{a, 3'b000} +: 8];

endmodule

module key_schedule_engine #(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [0:32*NK-1]  key,
    output logic              busy,
    output logic              done,
    output logic              keys_valid,
    input  logic              rk_req,
    input  logic [3:0]        rk_idx,
    output logic              rk_valid,
    output logic              rk_err,
    output logic [0:127]      rk_data
);

    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;
    localparam logic [1:0] S_READY  = 2'd3;

    localparam logic [5:0] NK_W     = 6'(NK);
    localparam logic [5:0] LAST_W   = 6'(NW - 1);
    localparam logic [2:0] LAST_POS = 3'(NK - 1);
    localparam logic [3:0] NR_IDX   = 4'(NR);

    logic [1:0]        state;
    logic [0:32*NK-1]  key_q;
    logic [31:0]       w [0:NW-1];
    logic [5:0]        wi;
    logic [2:0]        pos;
    logic [7:0]        rc;

    logic [31:0] prev_w;
    logic [31:0] back_w;
    logic [31:0] rot_w;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp_w;
    logic [5:0]  rk_base;

    assign busy       = (state == S_LOAD) || (state == S_EXPAND);
    assign keys_valid = (state == S_READY);

    assign prev_w  = w[wi - 6'd1];
    assign back_w  = w[wi - NK_W];
    assign rot_w   = {prev_w[23:0], prev_w[31:24]};
    assign sub_in  = (pos == 3'd0) ? rot_w : prev_w;
    assign rk_base = {rk_idx, 2'b00};

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sbox
            key_schedule_sbox u_sbox (
                .a (sub_in[8*b +: 8]),
                .y (sub_out[8*b +: 8])
            );
        end
    endgenerate

    // pos tracks i mod NK so no divider is needed for the temp rule or Rcon.
    always_comb begin
        temp_w = prev_w;
        if (pos == 3'd0) begin
            temp_w = sub_out ^ {rc, 24'h000000};
        end else if ((NK == 8) && (pos == 3'd4)) begin
            temp_w = sub_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
            wi    <= 6'd0;
            pos   <= 3'd0;
            rc    <= 8'h01;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_READY: begin
                    if (start) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_EXPAND;
                    wi    <= NK_W;
                    pos   <= 3'd0;
                    rc    <= 8'h01;
                end
                S_EXPAND: begin
                    if (wi == LAST_W) begin
                        state <= S_READY;
                        done  <= 1'b1;
                    end
                    wi  <= wi + 6'd1;
                    pos <= (pos == LAST_POS) ? 3'd0 : pos + 3'd1;
                    if (pos == 3'd0) begin
                        rc <= {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Word storage is never cleared; it is unreadable whenever keys_valid is low.
    always_ff @(posedge clk) begin
        if (start && ((state == S_IDLE) || (state == S_READY))) begin
            key_q <= key;
        end
        if (state == S_LOAD) begin
            for (int k = 0; k < NK; k++) begin
                w[k] <= key_q[32*k +: 32];
            end
        end
        if (state == S_EXPAND) begin
            w[wi] <= back_w ^ temp_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
            rk_data  <= '0;
        end else begin
            rk_valid <= rk_req;
            rk_err   <= 1'b0;
            rk_data  <= '0;
            if (rk_req) begin
                if ((state == S_READY) && (rk_idx <= NR_IDX)) begin
                    rk_data <= {w[rk_base], w[rk_base + 6'd1],
                                w[rk_base + 6'd2], w[rk_base + 6'd3]};
                end else begin
                    rk_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_engine.sv
// Self-checking bench for key_schedule_engine: NK=4/6/8 instances, vector table
// of round-key reads through a response scoreboard, plus multi-cycle sequences.

module tb_key_schedule_engine;

    localparam logic [127:0] K4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R4_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R4_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z4_10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        int           sel;
        logic [3:0]   idx;
        logic         err;
        logic [127:0] data;
    } vec_t;

    typedef struct {
        logic         err;
        logic [127:0] data;
    } exp_t;

    logic clk;
    logic reset;
    logic start4, start6, start8;
    logic [0:127] key4;
    logic [0:191] key6;
    logic [0:255] key8;
    logic busy4, busy6, busy8;
    logic done4, done6, done8;
    logic kv4, kv6, kv8;
    logic rk_req4, rk_req6, rk_req8;
    logic [3:0] rk_idx;
    logic rkv4, rkv6, rkv8;
    logic err4, err6, err8;
    logic [0:127] data4, data6, data8;

    exp_t q4[$];
    exp_t q6[$];
    exp_t q8[$];
    vec_t vecs [13];

    int compared;
    int mismatched;

    key_schedule_engine #(.NK(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .key(key4), .busy(busy4),
        .done(done4), .keys_valid(kv4), .rk_req(rk_req4), .rk_idx(rk_idx),
        .rk_valid(rkv4), .rk_err(err4), .rk_data(data4)
    );

    key_schedule_engine #(.NK(6)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .key(key6), .busy(busy6),
        .done(done6), .keys_valid(kv6), .rk_req(rk_req6), .rk_idx(rk_idx),
        .rk_valid(rkv6), .rk_err(err6), .rk_data(data6)
    );

    key_schedule_engine #(.NK(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .key(key8), .busy(busy8),
        .done(done8), .keys_valid(kv8), .rk_req(rk_req8), .rk_idx(rk_idx),
        .rk_valid(rkv8), .rk_err(err8), .rk_data(data8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one read request for a cycle and queue the response it must produce.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        e.err  = v.err;
        e.data = v.data;
        rk_req4 = (v.sel == 4);
        rk_req6 = (v.sel == 6);
        rk_req8 = (v.sel == 8);
        rk_idx  = v.idx;
        if (v.sel == 4) q4.push_back(e);
        else if (v.sel == 6) q6.push_back(e);
        else q8.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clearReq();
        rk_req4 = 1'b0;
        rk_req6 = 1'b0;
        rk_req8 = 1'b0;
    endtask

    task automatic waitDone4(input int elapsed, input int expected, input string name);
        int seen;
        int pulses;
        seen = 0;
        pulses = 0;
        for (int cyc = elapsed + 1; cyc <= expected + 6; cyc++) begin
            @(posedge clk);
            #1;
            if (done4) begin
                pulses++;
                if (seen == 0) seen = cyc;
            end
        end
        checkOutput(name, seen, expected);
        checkOutput({name, " pulses"}, pulses, 1);
        checkOutput({name, " keys_valid"}, kv4, 1'b1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rkv4) begin
            if (q4.size() == 0) checkOutput("unexpected rk_valid nk4", 1, 0);
            else begin
                e = q4.pop_front();
                checkOutput("rk_err nk4", err4, e.err);
                checkOutput("rk_data nk4", data4, e.data);
            end
        end
        if (rkv6) begin
            if (q6.size() == 0) checkOutput("unexpected rk_valid nk6", 1, 0);
            else begin
                e = q6.pop_front();
                checkOutput("rk_err nk6", err6, e.err);
                checkOutput("rk_data nk6", data6, e.data);
            end
        end
        if (rkv8) begin
            if (q8.size() == 0) checkOutput("unexpected rk_valid nk8", 1, 0);
            else begin
                e = q8.pop_front();
                checkOutput("rk_err nk8", err8, e.err);
                checkOutput("rk_data nk8", data8, e.data);
            end
        end
    end

    initial begin
        int seen4, seen6, seen8;
        int pulses4, pulses6, pulses8;
        exp_t e;

        vecs[0]  = '{4, 4'd0,  1'b0, K4};
        vecs[1]  = '{4, 4'd1,  1'b0, R4_1};
        vecs[2]  = '{4, 4'd10, 1'b0, R4_10};
        vecs[3]  = '{4, 4'd11, 1'b1, 128'h0};
        vecs[4]  = '{4, 4'd15, 1'b1, 128'h0};
        vecs[5]  = '{6, 4'd0,  1'b0, 128'h8e73b0f7da0e6452c810f32b809079e5};
        vecs[6]  = '{6, 4'd12, 1'b0, 128'he98ba06f448c773c8ecc720401002202};
        vecs[7]  = '{6, 4'd13, 1'b1, 128'h0};
        vecs[8]  = '{8, 4'd0,  1'b0, 128'h603deb1015ca71be2b73aef0857d7781};
        vecs[9]  = '{8, 4'd1,  1'b0, 128'h1f352c073b6108d72d9810a30914dff4};
        vecs[10] = '{8, 4'd2,  1'b0, 128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[11] = '{8, 4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[12] = '{8, 4'd15, 1'b1, 128'h0};

        compared = 0;
        mismatched = 0;
        reset = 1'b1;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        key4 = K4; key6 = K6; key8 = K8;
        rk_idx = 4'd0;
        clearReq();
        rk_req4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ctrl nk4", {busy4, done4, kv4, rkv4, err4}, 5'b0);
        checkOutput("reset ctrl nk6", {busy6, done6, kv6, rkv6, err6}, 5'b0);
        checkOutput("reset ctrl nk8", {busy8, done8, kv8, rkv8, err8}, 5'b0);
        checkOutput("reset rk_data nk4", data4, 128'h0);
        reset = 1'b0;
        rk_req4 = 1'b0;

        applyStimulus('{4, 4'd0, 1'b1, 128'h0});
        clearReq();

        // All three expand together; nk4 gets an ignored restart and an early read.
        $display("[TB] expanding NK=4/6/8 keys");
        start4 = 1'b1; start6 = 1'b1; start8 = 1'b1;
        seen4 = 0; seen6 = 0; seen8 = 0;
        pulses4 = 0; pulses6 = 0; pulses8 = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
                checkOutput("busy in LOAD nk4", {busy4, kv4}, 2'b10);
            end
            if (cyc == 5) begin
                rk_req4 = 1'b1;
                rk_idx = 4'd1;
                e.err = 1'b1;
                e.data = 128'h0;
                q4.push_back(e);
            end
            if (cyc == 6) rk_req4 = 1'b0;
            if (cyc == 10) begin
                start4 = 1'b1;
                key4 = '0;
            end
            if (cyc == 11) start4 = 1'b0;
            if (done4) begin pulses4++; if (seen4 == 0) seen4 = cyc; end
            if (done6) begin pulses6++; if (seen6 == 0) seen6 = cyc; end
            if (done8) begin pulses8++; if (seen8 == 0) seen8 = cyc; end
        end
        checkOutput("done latency nk4", seen4, 42);
        checkOutput("done latency nk6", seen6, 48);
        checkOutput("done latency nk8", seen8, 54);
        checkOutput("done pulses", {pulses4[3:0], pulses6[3:0], pulses8[3:0]}, 12'h111);
        checkOutput("ready flags", {kv4, kv6, kv8, busy4, busy6, busy8}, 6'b111000);

        for (int n = 0; n < 13; n++) applyStimulus(vecs[n]);
        clearReq();

        // Rekey with an all-zero key; the same-edge read still sees the old schedule.
        $display("[TB] rekey nk4 with zero key");
        key4 = '0;
        start4 = 1'b1;
        rk_req4 = 1'b1;
        rk_idx = 4'd10;
        e.err = 1'b0; e.data = R4_10; q4.push_back(e);
        @(posedge clk);
        #1;
        start4 = 1'b0;
        rk_idx = 4'd1;
        e.err = 1'b1; e.data = 128'h0; q4.push_back(e);
        @(posedge clk);
        #1;
        rk_req4 = 1'b0;
        waitDone4(2, 42, "rekey done latency");
        applyStimulus('{4, 4'd10, 1'b0, Z4_10});
        applyStimulus('{4, 4'd11, 1'b1, 128'h0});
        clearReq();

        // Abort an expansion with reset, then run a clean one.
        $display("[TB] reset during expansion");
        key4 = K4;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("after abort ctrl nk4", {busy4, kv4, done4}, 3'b000);
        pulses4 = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done4) pulses4++;
        end
        checkOutput("no done after abort", pulses4, 0);
        applyStimulus('{4, 4'd1, 1'b1, 128'h0});
        clearReq();
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        waitDone4(1, 42, "restart done latency");
        applyStimulus('{4, 4'd1, 1'b0, R4_1});
        applyStimulus('{4, 4'd10, 1'b0, R4_10});
        clearReq();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", q4.size() + q6.size() + q8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/key_schedule_engine.md
KEY_SCHEDULE_ENGINE -- requirements
Module: key_schedule_engine

Interface
REQ-001 SHALL provide parameter NK, default 4: key length in 32-bit words; legal values 4, 6, 8.
REQ-002 SHALL derive localparams NR = NK+6 (round count) and NW = 4*(NR+1) (total words: 44/52/60).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request expansion of key; sampled only in IDLE or READY.
REQ-006 key  input  [0:32*NK-1]  cipher key; bit 0 = MSB of word w[0].
REQ-007 busy  output  1  high in LOAD and EXPAND.
REQ-008 done  output  1  one-cycle pulse on entry to READY.
REQ-009 keys_valid  output  1  high while READY (full schedule stored).
REQ-010 rk_req  input  1  round-key read request.
REQ-011 rk_idx  input  4  round index 0..NR.
REQ-012 rk_valid  output  1  one-cycle pulse, one cycle after rk_req.
REQ-013 rk_err  output  1  qualifies rk_valid; request rejected.
REQ-014 rk_data  output  [0:127]  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in bits 0..31.

Function
REQ-015 SHALL implement states IDLE, LOAD, EXPAND, READY.
REQ-016 IDLE/READY + start=1 -> LOAD; key latched that edge; keys_valid cleared that edge.
REQ-017 LOAD: writes w[0..NK-1] from latched key in one cycle -> EXPAND with i = NK.
REQ-018 EXPAND: one word per cycle, w[i] = w[i-NK] xor temp, temp = w[i-1] transformed per REQ-019.
REQ-019 temp rule: i mod NK = 0 -> SubWord(RotWord(w[i-1])) xor Rcon[i/NK]; NK=8 and i mod 8 = 4 -> SubWord(w[i-1]); else w[i-1] unchanged.
REQ-020 RotWord = left rotate by one byte; SubWord = AES S-box on each of 4 bytes (4 combinational S-box instances, internal); Rcon[j] = {rc_j, 24'h0}, rc_1 = 01, rc_j = xtime(rc_{j-1}) (01,02,04,08,10,20,40,80,1b,36).
REQ-021 After writing w[NW-1] -> READY; done pulses the first READY cycle.
REQ-022 Latency start -> done high: 1 + (NW-NK) + 1 cycles = 42 (NK=4), 48 (NK=6), 54 (NK=8).
REQ-023 start during LOAD/EXPAND SHALL be ignored; expansion in progress unaffected.
REQ-024 start in READY SHALL restart (rekey); prior schedule unreadable from that edge.
REQ-025 rk_req with keys_valid=1 and rk_idx <= NR -> next cycle rk_valid=1, rk_err=0, rk_data = round key rk_idx.
REQ-026 rk_req with keys_valid=0 or rk_idx > NR -> next cycle rk_valid=1, rk_err=1, rk_data = 0.
REQ-027 rk_req and start same edge in READY -> read judged against pre-edge keys_valid (served, rk_err=0).
REQ-028 Back-to-back rk_req every cycle SHALL be accepted; throughput one round key per cycle.
REQ-029 Word storage: NW x 32 registers; no external memory.

Reset
REQ-030 reset=1 -> next edge: state IDLE; busy, done, keys_valid, rk_valid, rk_err = 0; rk_data = 0.
REQ-031 reset mid-LOAD/EXPAND SHALL abort; no done pulse; schedule invalid until a new full expansion.
REQ-032 reset dominates start and rk_req on the same edge.
REQ-033 Word storage contents need not be cleared by reset (invisible while keys_valid=0).

Verification
REQ-034 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done 42 cycles later; rk_idx=1 -> a0fafe1788542cb123a339392a6c7605; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-035 NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 48 cycles; rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
REQ-036 NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 54; rk_idx=2 -> 9ba354118e6925afa51a8b5f2067fcde; rk_idx=14 -> fe4890d1e6188d0b046df344706c631e.
REQ-037 NK=4: rk_req before done -> rk_err=1, rk_data=0; rk_idx=11 after done -> rk_err=1; start pulsed at cycle 10 of expansion -> done still at cycle 42 with original key.
REQ-038 NK=4: reset at cycle 20 of expansion -> no done, keys_valid=0; new start -> correct schedule 42 cycles later.
REQ-039 NK=4 READY: rekey with all-zero key -> rk_idx=10 = b4ef5bcb3e92e21123e951cf6f8f188e.
